smm_operand_packer: RTL and testbench
=====================================

SMM_OPERAND_PACKER -- requirements
Module: smm_operand_packer

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 32, element width in bits.
REQ-002 SHALL have parameter BUSWIDTH, default DATAWIDTH*4, packed 2x2 block width.
REQ-003 SHALL have parameter LATENCY, default 4, cooldown cycles after load; legal range 1..255.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port s_data  input  DATAWIDTH  element stream payload.
REQ-007 SHALL have port s_valid  input  1  payload valid.
REQ-008 SHALL have port s_ready  output  1  packer accepts a beat.
REQ-009 SHALL have port s_last  input  1  marks final element of a transaction.
REQ-010 SHALL have port sel_in  input  1  transaction mode: 0 = 2x2 by 2x2, 1 = 2x2 by 2x1 column.
REQ-011 SHALL have ports A and B, each output, BUSWIDTH, packed operands: bits [DATAWIDTH-1:0] = element 00, then 01, 10, 11 upward.
REQ-012 SHALL have port sel  output  1  mode of the currently issued operands.
REQ-013 SHALL have port load  output  1  single-cycle start pulse to the multiplier.
REQ-014 SHALL have port busy  output  1  high whenever not in COLLECT.
REQ-015 SHALL have port err  output  1  sticky framing error flag.

Function
REQ-016 SHALL accept a beat only when s_valid and s_ready are both high; s_ready SHALL NOT depend on s_valid.
REQ-017 SHALL implement states COLLECT, ISSUE, WAIT; reset state COLLECT.
REQ-018 COLLECT: s_ready=1; sel_in is sampled on the first beat (count 0) and held for the transaction; later sel_in changes are ignored.
REQ-019 Element order, mode 0 (8 beats): A00, A01, A10, A11, B00, B01, B10, B11.
REQ-020 Element order, mode 1 (6 beats): A00, A01, A10, A11, B00, B10; B01 and B11 lanes SHALL be driven zero.
REQ-021 Beats SHALL be written to internal staging registers; A, B, sel SHALL NOT change during COLLECT or WAIT.
REQ-022 On acceptance of the final beat, the FSM SHALL move to ISSUE next cycle, with A, B, sel updated from staging in that same edge.
REQ-023 ISSUE: exactly one cycle, load=1, s_ready=0; then WAIT.
REQ-024 WAIT: s_ready=0, load=0 for exactly LATENCY cycles, then COLLECT.
REQ-025 Beat-to-next-acceptance minimum: final beat at cycle t gives load at t+1 and s_ready high again at t+2+LATENCY.
REQ-026 A, B, sel SHALL hold their values from ISSUE until the next ISSUE.
REQ-027 Element counter SHALL reset to 0 on entry to ISSUE; no wrap into a second transaction without ISSUE/WAIT.

Reset
REQ-028 With rst low at a clock edge: state COLLECT, counter 0, staging 0, A=0, B=0, sel=0, load=0, busy=0, err=0; s_ready=1 from the first cycle after rst goes high.
REQ-029 Reset mid-collection or mid-WAIT SHALL discard the partial transaction; no load pulse SHALL follow.

Configuration
REQ-030 Macro SMM_PACK_FRAME_CHECK_EN: when defined, err SHALL set when s_last is high on any accepted beat other than the final one, or low on the final beat; err clears only on reset; transfer proceeds regardless.
REQ-031 Without SMM_PACK_FRAME_CHECK_EN: s_last ignored, err tied 0, port list unchanged.

Verification
REQ-032 Reset then mode 0, beats 1..8 back-to-back, s_last on beat 8 -> one load pulse next cycle; A=0x00000004_00000003_00000002_00000001, B=0x00000008_00000007_00000006_00000005, sel=0.
REQ-033 Mode 1, beats 1..6 -> A as above, B=0x00000000_00000006_00000000_00000005, sel=1, load one cycle.
REQ-034 LATENCY=4, s_valid held high -> s_ready low for 5 cycles (ISSUE + 4 WAIT); A, B stable throughout; no beat lost.
REQ-035 Reset low after 3 beats, then 8 fresh beats -> only one load, with the fresh data; err=0.
REQ-036 With macro defined, s_last on beat 5 of mode 0 -> err=1 sticky, load still issued after beat 8; without macro err stays 0.
REQ-037 sel_in toggled after beat 1 and gaps in s_valid -> mode follows sel_in at beat 1; packed data unaffected by gaps.

Source files
------------

// File: rtl/smm_operand_packer_if.sv
// Element-stream input and packed 2x2 operand output bundle for smm_operand_packer.
interface smm_operand_packer_if #(
    parameter int DATAWIDTH = 32,
    parameter int BUSWIDTH  = DATAWIDTH*4
);
    logic [DATAWIDTH-1:0] s_data;
    logic                 s_valid;
    logic                 s_ready;
    logic                 s_last;
    logic                 sel_in;
    logic [BUSWIDTH-1:0]  A;
    logic [BUSWIDTH-1:0]  B;
    logic                 sel;
    logic                 load;
    logic                 busy;
    logic                 err;

    modport master (
        output s_data, s_valid, s_last, sel_in,
        input  s_ready, A, B, sel, load, busy, err
    );

    modport slave (
        input  s_data, s_valid, s_last, sel_in,
        output s_ready, A, B, sel, load, busy, err
    );
endinterface

// File: rtl/smm_operand_packer.sv
// Collects a 2x2 (or 2x2 + 2x1 column) operand stream, issues one load pulse, then cools down.
// Optional framing check on s_last enabled by defining SMM_PACK_FRAME_CHECK_EN.
module smm_operand_packer #(
    parameter int DATAWIDTH = 32,
    parameter int BUSWIDTH  = DATAWIDTH*4,
    parameter int LATENCY   = 4
) (
    input logic clk,
    input logic rst,
    smm_operand_packer_if.slave bus
);
    typedef enum logic [1:0] {COLLECT, ISSUE, WAIT} state_t;

    state_t                    state, state_nxt;
    logic [2:0]                cnt;
    logic [7:0]                wcnt;
    logic                      mode_q, mode_cur;
    logic                      accept, final_beat;
    logic [3:0][DATAWIDTH-1:0] stg_a, stg_b, a_nxt, b_nxt;

    assign bus.s_ready = (state == COLLECT);
    assign bus.load    = (state == ISSUE);
    assign bus.busy    = (state != COLLECT);

    assign accept     = bus.s_valid && bus.s_ready;
    // Mode is taken live from sel_in only on the first beat, then latched.
    assign mode_cur   = (cnt == 3'd0) ? bus.sel_in : mode_q;
    assign final_beat = mode_cur ? (cnt == 3'd5) : (cnt == 3'd7);

    always_comb begin
        a_nxt = stg_a;
        b_nxt = stg_b;
        if (accept) begin
            if (!cnt[2])
                a_nxt[cnt[1:0]] = bus.s_data;
            else if (mode_cur)
                b_nxt[{cnt[0], 1'b0}] = bus.s_data;
            else
                b_nxt[cnt[1:0]] = bus.s_data;
        end
        // Column mode: B01/B11 lanes carry no data, so stale staging is masked off.
        if (mode_cur) begin
            b_nxt[1] = '0;
            b_nxt[3] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= COLLECT;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            COLLECT: if (accept && final_beat) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (wcnt == 8'(LATENCY-1)) state_nxt = COLLECT;
            default: state_nxt = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt     <= '0;
            wcnt    <= '0;
            mode_q  <= 1'b0;
            stg_a   <= '0;
            stg_b   <= '0;
            bus.A   <= '0;
            bus.B   <= '0;
            bus.sel <= 1'b0;
        end else begin
            if (accept) begin
                stg_a <= a_nxt;
                stg_b <= b_nxt;
                if (cnt == 3'd0) mode_q <= bus.sel_in;
                if (final_beat) begin
                    cnt     <= '0;
                    bus.A   <= BUSWIDTH'(a_nxt);
                    bus.B   <= BUSWIDTH'(b_nxt);
                    bus.sel <= mode_cur;
                end else begin
                    cnt <= cnt + 3'd1;
                end
            end
            wcnt <= (state == WAIT) ? wcnt + 8'd1 : 8'd0;
        end
    end

`ifdef SMM_PACK_FRAME_CHECK_EN
    logic err_q;
    always_ff @(posedge clk) begin
        if (!rst)
            err_q <= 1'b0;
        else if (accept && (bus.s_last != final_beat))
            err_q <= 1'b1;
    end
    assign bus.err = err_q;
`else
    logic unused_last;
    assign unused_last = bus.s_last;
    assign bus.err     = 1'b0;
`endif
endmodule

// File: tb/tb_smm_operand_packer.sv
// Directed bench for smm_operand_packer: modes, cooldown stall, resets, sel_in latch, framing.
module tb_smm_operand_packer;
    localparam int DW = 32;
    localparam int BW = DW*4;

`ifdef SMM_PACK_FRAME_CHECK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    localparam logic [BW-1:0] A_1234 = 128'h00000004_00000003_00000002_00000001;
    localparam logic [BW-1:0] B_5678 = 128'h00000008_00000007_00000006_00000005;
    localparam logic [BW-1:0] B_COL  = 128'h00000000_00000006_00000000_00000005;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk = 0;
    int   n_bad = 0;
    int   n_load = 0;
    int   stall;
    int   ld0;

    always #5 clk = ~clk;

    smm_operand_packer_if #(.DATAWIDTH(DW), .BUSWIDTH(BW)) bus ();

    smm_operand_packer #(.DATAWIDTH(DW), .BUSWIDTH(BW), .LATENCY(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always @(posedge clk) if (bus.load) n_load++;

    task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the beat is accepted.
    task automatic send(input logic [DW-1:0] d, input logic sl, input logic si, output int st);
        st = 0;
        bus.s_data  = d;
        bus.s_last  = sl;
        bus.sel_in  = si;
        bus.s_valid = 1'b1;
        while (!bus.s_ready && st < 50) begin
            @(negedge clk);
            st++;
        end
        if (!bus.s_ready) chk("ready_timeout", 0, 1);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_reset();
        bus.s_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        bus.s_data  = '0;
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        bus.sel_in  = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_A", bus.A, 0);
        chk("rst_B", bus.B, 0);
        chk("rst_ctl", {bus.sel, bus.load, bus.busy, bus.err, bus.s_ready}, 5'b00001);
        rst = 1'b1;

        // Mode 0, back-to-back beats 1..8
        ld0 = n_load;
        for (int i = 1; i <= 8; i++) begin
            send(DW'(i), i == 8, 1'b0, stall);
            if (i == 1) chk("m0_first_stall", stall, 0);
        end
        chk("m0_issue_ctl", {bus.load, bus.busy, bus.s_ready, bus.sel}, 4'b1100);
        chk("m0_A", bus.A, A_1234);
        chk("m0_B", bus.B, B_5678);
        chk("m0_err", bus.err, 0);

        // Mode 1 with s_valid held through the cooldown; sel_in flips after beat 1; gaps.
        send(32'd1, 1'b0, 1'b1, stall);
        chk("cooldown_stall", stall, 5);
        chk("A_stable_wait", bus.A, A_1234);
        chk("B_stable_wait", bus.B, B_5678);
        chk("m0_load_count", n_load - ld0, 1);
        for (int i = 2; i <= 6; i++) begin
            if (i == 3 || i == 5) idle(2);
            send(DW'(i), i == 6, 1'b0, stall);
        end
        chk("m1_issue_ctl", {bus.load, bus.sel}, 2'b11);
        chk("m1_A", bus.A, A_1234);
        chk("m1_B", bus.B, B_COL);
        idle(1);
        chk("m1_load_one_cycle", bus.load, 0);
        idle(6);
        chk("m1_load_count", n_load - ld0, 2);

        // Mode 0 with sel_in raised after beat 1 and irregular gaps
        for (int i = 1; i <= 8; i++) begin
            if (i == 2 || i == 7) idle(3);
            send(DW'(i), i == 8, i != 1, stall);
        end
        chk("gap_sel", {bus.load, bus.sel}, 2'b10);
        chk("gap_A", bus.A, A_1234);
        chk("gap_B", bus.B, B_5678);
        idle(6);

        // Reset after 3 beats, then 8 fresh beats
        ld0 = n_load;
        for (int i = 1; i <= 3; i++) send(DW'(32'h10 + i), 1'b0, 1'b0, stall);
        pulse_reset();
        chk("midrst_A", bus.A, 0);
        chk("midrst_ctl", {bus.busy, bus.s_ready, bus.err}, 3'b010);
        for (int i = 1; i <= 8; i++) send(DW'(32'h20 + i), i == 8, 1'b0, stall);
        chk("fresh_A", bus.A, 128'h00000024_00000023_00000022_00000021);
        chk("fresh_B", bus.B, 128'h00000028_00000027_00000026_00000025);
        chk("fresh_err", bus.err, 0);
        idle(6);
        chk("fresh_load_count", n_load - ld0, 1);

        // Reset in the middle of WAIT: no further load, back to COLLECT
        for (int i = 1; i <= 8; i++) send(DW'(i), i == 8, 1'b0, stall);
        ld0 = n_load;
        idle(2);
        pulse_reset();
        chk("waitrst_ctl", {bus.busy, bus.s_ready, bus.load}, 3'b010);
        idle(6);
        chk("waitrst_load_count", n_load - ld0, 1);

        // Early s_last on beat 5 of mode 0
        ld0 = n_load;
        for (int i = 1; i <= 8; i++) begin
            send(DW'(i), i == 5 || i == 8, 1'b0, stall);
            if (i == 5) chk("frame_err_set", bus.err, ERR_EXP);
        end
        chk("frame_A", bus.A, A_1234);
        chk("frame_B", bus.B, B_5678);
        idle(6);
        chk("frame_load_count", n_load - ld0, 1);
        chk("frame_err_sticky", bus.err, ERR_EXP);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
